// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic cells.
// Contents:
//   DEFAULT_WIDTH - default operand width for the serial cells
//   subState_e    - IDLE / RUN / DONE control states of a serial cell
//   borrowOut()   - borrow-out of a one-bit full subtractor stage
package arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } subState_e;

  // A borrow is produced when the subtrahend bit exceeds the minuend bit, or
  // when the two bits are equal and a borrow is already pending from below.
  function automatic logic borrowOut(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor; purely combinational.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow-in from the less significant stage
//   diff - difference bit, a ^ b ^ bin
//   bout - borrow-out toward the more significant stage
module full_subtractor
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // The difference bit is the parity of the three inputs; the borrow uses the
  // package helper so every serial cell agrees on the same borrow equation.
  assign diff = a ^ b ^ bin;
  assign bout = borrowOut(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, LSB first,
// one bit per clock, using a single full subtractor stage and a borrow
// flip-flop that carries the borrow between cycles.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - operands a/b valid
//   in_ready  - block can accept operands (IDLE only)
//   a, b      - minuend / subtrahend, unsigned, WIDTH bits
//   out_valid - diff/borrow valid (DONE only)
//   out_ready - consumer takes the result
//   diff      - (a - b) mod 2^WIDTH
//   borrow    - 1 iff a < b unsigned
//   busy      - high in RUN or DONE
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  subState_e        state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] res_q;
  logic             bff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             inReady_q;
  logic             outValid_q;
  logic             busy_q;

  logic             stageDiff;
  logic             stageBout;
  logic [WIDTH-1:0] aSh_d;
  logic [WIDTH-1:0] bSh_d;
  logic [WIDTH-1:0] res_d;

  // The single per-bit stage always looks at the current LSBs of the operand
  // shift registers and the borrow carried over from the previous cycle.
  full_subtractor u_stage (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .bin  (bff_q),
    .diff (stageDiff),
    .bout (stageBout)
  );

  // Operands drain out of the bottom; each new difference bit enters the
  // result at the top, so after WIDTH shifts the first bit sits at the LSB.
  assign aSh_d = {1'b0, aSh_q[WIDTH-1:1]};
  assign bSh_d = {1'b0, bSh_q[WIDTH-1:1]};
  assign res_d = {stageDiff, res_q[WIDTH-1:1]};

  // Control FSM and datapath registers. Handshake outputs are registered and
  // updated together with the state so they always match it exactly. The
  // counter holds at its last value on the final bit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      res_q      <= '0;
      bff_q      <= 1'b0;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aSh_q     <= a;
            bSh_q     <= b;
            bff_q     <= 1'b0;
            cnt_q     <= '0;
            state_q   <= RUN;
            inReady_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          aSh_q <= aSh_d;
          bSh_q <= bSh_d;
          res_q <= res_d;
          bff_q <= stageBout;
          if (cnt_q == LAST_CNT) begin
            borrow_q   <= stageBout;
            state_q    <= DONE;
            outValid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign busy      = busy_q;
  assign diff      = res_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8, WIDTH=2 and WIDTH=64.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       inValid8, inReady8, outValid8, outReady8, borrow8, busy8;
  logic [7:0] a8, b8, diff8;

  logic       inValid2, inReady2, outValid2, outReady2, borrow2, busy2;
  logic [1:0] a2, b2, diff2;

  logic        inValid64, inReady64, outValid64, outReady64, borrow64, busy64;
  logic [63:0] a64, b64, diff64;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid8), .in_ready(inReady8),
    .a(a8), .b(b8), .out_valid(outValid8), .out_ready(outReady8),
    .diff(diff8), .borrow(borrow8), .busy(busy8)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady2),
    .a(a2), .b(b2), .out_valid(outValid2), .out_ready(outReady2),
    .diff(diff2), .borrow(borrow2), .busy(busy2)
  );

  serial_subtractor #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid64), .in_ready(inReady64),
    .a(a64), .b(b64), .out_valid(outValid64), .out_ready(outReady64),
    .diff(diff64), .borrow(borrow64), .busy(busy64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one WIDTH=8 operation from a point just after a clock edge, wait for
  // out_valid and report the result plus the edges counted after acceptance.
  task automatic doOp8(input logic [7:0] opA, input logic [7:0] opB,
                       output logic [7:0] gotD, output logic gotB, output int lat);
    int guard;
    guard = 0;
    inValid8 = 1'b1; a8 = opA; b8 = opB;
    while (!inReady8 && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    inValid8 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!outValid8 && lat < 200);
    if (!outValid8) begin
      checks++; errors++;
      $display("[TB] FAIL op8_timeout out_valid=%b required 1", outValid8);
    end
    gotD = diff8; gotB = borrow8;
  endtask

  task automatic doOp2(input logic [1:0] opA, input logic [1:0] opB,
                       output logic [1:0] gotD, output logic gotB, output int lat);
    inValid2 = 1'b1; a2 = opA; b2 = opB;
    @(posedge clk); #1;
    inValid2 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!outValid2 && lat < 200);
    if (!outValid2) begin
      checks++; errors++;
      $display("[TB] FAIL op2_timeout out_valid=%b required 1", outValid2);
    end
    gotD = diff2; gotB = borrow2;
  endtask

  task automatic doOp64(input logic [63:0] opA, input logic [63:0] opB,
                        output logic [63:0] gotD, output logic gotB, output int lat);
    inValid64 = 1'b1; a64 = opA; b64 = opB;
    @(posedge clk); #1;
    inValid64 = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!outValid64 && lat < 200);
    if (!outValid64) begin
      checks++; errors++;
      $display("[TB] FAIL op64_timeout out_valid=%b required 1", outValid64);
    end
    gotD = diff64; gotB = borrow64;
  endtask

  // Reset values while held in reset and just after release.
  task automatic test_reset();
    logic [11:0] got;
    got = {inReady8, outValid8, busy8, borrow8, diff8};
    checks++;
    if (got !== 12'h800) begin
      errors++;
      $display("[TB] FAIL reset_state got %h required 800", got);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inReady8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release in_ready=%b busy=%b required 1/0", inReady8, busy8);
    end
  endtask

  // 0x5A - 0x23 with latency and return to IDLE.
  task automatic test_basic();
    logic [7:0] d; logic bo; int lat;
    outReady8 = 1'b1;
    doOp8(8'h5A, 8'h23, d, bo, lat);
    checks++;
    if (d !== 8'h37 || bo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_result got %h/%b required 37/0", d, bo);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d required 8", lat);
    end
    @(posedge clk); #1;
    checks++;
    if (outValid8 !== 1'b0 || inReady8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle out_valid=%b in_ready=%b busy=%b required 0/1/0",
               outValid8, inReady8, busy8);
    end
  endtask

  // Underflow, equal operands and all-ones minus zero.
  task automatic test_corners();
    logic [7:0] va [3] = '{8'h00, 8'h80, 8'hFF};
    logic [7:0] vb [3] = '{8'h01, 8'h80, 8'h00};
    logic [7:0] ed [3] = '{8'hFF, 8'h00, 8'hFF};
    logic       eb [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] d; logic bo; int lat;
    for (int i = 0; i < 3; i++) begin
      doOp8(va[i], vb[i], d, bo, lat);
      checks++;
      if (d !== ed[i] || bo !== eb[i]) begin
        errors++;
        $display("[TB] FAIL corner%0d got %h/%b required %h/%b", i, d, bo, ed[i], eb[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  // Stall in DONE with in_valid active and operands toggling.
  task automatic test_backpressure();
    logic [7:0] d; logic bo; int lat;
    outReady8 = 1'b0;
    doOp8(8'hC3, 8'h3C, d, bo, lat);
    checks++;
    if (d !== 8'h87 || bo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_result got %h/%b required 87/0", d, bo);
    end
    for (int i = 0; i < 5; i++) begin
      inValid8 = 1'b1;
      a8 = 8'(i * 8'h11);
      b8 = ~a8;
      @(posedge clk); #1;
      checks++;
      if (outValid8 !== 1'b1 || inReady8 !== 1'b0 || diff8 !== 8'h87 || borrow8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d out_valid=%b in_ready=%b diff=%h borrow=%b required 1/0/87/0",
                 i, outValid8, inReady8, diff8, borrow8);
      end
    end
    a8 = 8'h20; b8 = 8'h30;
    outReady8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inReady8 !== 1'b1 || busy8 !== 1'b0 || outValid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release in_ready=%b busy=%b out_valid=%b required 1/0/0",
               inReady8, busy8, outValid8);
    end
    @(posedge clk); #1;
    inValid8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || inReady8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_accept busy=%b in_ready=%b required 1/0", busy8, inReady8);
    end
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!outValid8 && lat < 200);
    checks++;
    if (lat !== 8 || diff8 !== 8'hF0 || borrow8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_next lat=%0d diff=%h borrow=%b required 8/f0/1", lat, diff8, borrow8);
    end
    @(posedge clk); #1;
  endtask

  // Reset pulsed between edges during RUN, then a fresh operation.
  task automatic test_async_reset();
    logic [7:0] d; logic bo; int lat;
    logic [11:0] got;
    inValid8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
    @(posedge clk); #1;
    inValid8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    got = {inReady8, outValid8, busy8, borrow8, diff8};
    checks++;
    if (got !== 12'h800) begin
      errors++;
      $display("[TB] FAIL areset_immediate got %h required 800", got);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (inReady8 !== 1'b1 || busy8 !== 1'b0 || outValid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL areset_idle in_ready=%b busy=%b out_valid=%b required 1/0/0",
               inReady8, busy8, outValid8);
    end
    doOp8(8'h10, 8'h01, d, bo, lat);
    checks++;
    if (d !== 8'h0F || bo !== 1'b0 || lat !== 8) begin
      errors++;
      $display("[TB] FAIL areset_fresh got %h/%b lat %0d required 0f/0 lat 8", d, bo, lat);
    end
    @(posedge clk); #1;
  endtask

  // Continuous in_valid with 20 random pairs and random out_ready.
  task automatic test_back_to_back();
    logic [7:0] pa [20];
    logic [7:0] pb [20];
    logic [8:0] expQ [$];
    logic [8:0] exp;
    int sendIdx, recvIdx, cyc;
    logic willAcc, willTake;
    for (int i = 0; i < 20; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
    sendIdx = 0; recvIdx = 0; cyc = 0;
    while (recvIdx < 20 && cyc < 2000) begin
      outReady8 = 1'($urandom_range(0, 1));
      if (sendIdx < 20) begin
        inValid8 = 1'b1; a8 = pa[sendIdx]; b8 = pb[sendIdx];
      end else begin
        inValid8 = 1'b0;
      end
      willAcc  = inValid8 && inReady8;
      willTake = outValid8 && outReady8;
      if (willTake) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_spurious diff=%h borrow=%b required no result", diff8, borrow8);
        end else begin
          exp = expQ.pop_front();
          if ({borrow8, diff8} !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_result%0d got %b/%h required %b/%h",
                     recvIdx, borrow8, diff8, exp[8], exp[7:0]);
          end
        end
        recvIdx++;
      end
      if (willAcc) begin
        expQ.push_back({(a8 < b8), 8'(a8 - b8)});
        sendIdx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    inValid8 = 1'b0;
    outReady8 = 1'b1;
    checks++;
    if (recvIdx !== 20 || sendIdx !== 20 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_count sent %0d received %0d pending %0d required 20/20/0",
               sendIdx, recvIdx, expQ.size());
    end
    @(posedge clk); #1;
  endtask

  // WIDTH=2 exhaustive.
  task automatic test_width2();
    logic [1:0] d; logic bo; int lat;
    logic [1:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ea = 2'(i); eb = 2'(j);
        doOp2(ea, eb, d, bo, lat);
        checks++;
        if ({bo, d} !== {(i < j), 2'(ea - eb)} || lat !== 2) begin
          errors++;
          $display("[TB] FAIL w2_%0d_%0d got %b/%h lat %0d required %b/%h lat 2",
                   i, j, bo, d, lat, (i < j), 2'(ea - eb));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // WIDTH=64 corner values.
  task automatic test_width64();
    logic [63:0] maxV;
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [63:0] d; logic bo; int lat;
    maxV = '1;
    va = '{64'd0, 64'd0, 64'd1, maxV, 64'd0, maxV, 64'd1, maxV};
    vb = '{64'd0, 64'd1, 64'd0, 64'd0, maxV, maxV, maxV, 64'd1};
    for (int i = 0; i < 8; i++) begin
      doOp64(va[i], vb[i], d, bo, lat);
      checks++;
      if (d !== (va[i] - vb[i]) || bo !== (va[i] < vb[i]) || lat !== 64) begin
        errors++;
        $display("[TB] FAIL w64_%0d got %h/%b lat %0d required %h/%b lat 64",
                 i, d, bo, lat, va[i] - vb[i], (va[i] < vb[i]));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    inValid8 = 1'b0;  a8 = '0;  b8 = '0;  outReady8 = 1'b1;
    inValid2 = 1'b0;  a2 = '0;  b2 = '0;  outReady2 = 1'b1;
    inValid64 = 1'b0; a64 = '0; b64 = '0; outReady64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_width2();
    test_width64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
